// File: rtl/fl_nn_pkg.sv
// Shared types and FP32 field constants for the input-layer loader and its helpers.
package fl_nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        VALID = 2'd3
    } loader_state_e;

    localparam int          FP_EXP_MSB  = 30;
    localparam int          FP_EXP_LSB  = 23;
    localparam logic [7:0]  FP_EXP_ALL1 = 8'hFF;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    // An all-ones exponent encodes either infinity or NaN.
    function automatic logic fp32_is_special(input logic [31:0] word);
        return (word[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL1);
    endfunction

endpackage

// File: rtl/fp32_sanitize.sv
// Combinational Inf/NaN scrubber: replaces non-finite FP32 words with +0 and flags them.
module fp32_sanitize
    import fl_nn_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] clean,
    output logic        special
);

    // Substitute +0 for Inf/NaN; everything else passes unchanged.
    always_comb begin
        special = fp32_is_special(word);
        if (special) begin
            clean = FP_POS_ZERO;
        end else begin
            clean = word;
        end
    end

endmodule

// File: rtl/input_layer_loader.sv
// Steers a valid/ready sample stream into a bank of input neurons, one word per neuron.
// Optional build macro INPUT_SANITIZE_EN scrubs Inf/NaN words to +0 and sets a sticky flag.
module input_layer_loader
    import fl_nn_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0] neuron_enable,
    output logic [DATA_WIDTH-1:0] neuron_data,
    output logic                  layer_valid,
    input  logic                  layer_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  sanitized
);

    localparam int                    IDX_W      = $clog2(NUM_INPUTS);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0]      FIRST_IDX  = {IDX_W{1'b0}};
    localparam logic [NUM_INPUTS-1:0] ENABLE_LSB = {{(NUM_INPUTS-1){1'b0}}, 1'b1};

    loader_state_e           state_r;
    loader_state_e           next_state_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   word_clean_s;
    logic                    word_special_s;
    logic                    in_ready_r;
    logic [NUM_INPUTS-1:0]   neuron_enable_r;
    logic [DATA_WIDTH-1:0]   neuron_data_r;
    logic                    layer_valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    sanitized_r;

`ifdef INPUT_SANITIZE_EN
    fp32_sanitize u_sanitize (
        .word    (in_data),
        .clean   (word_clean_s),
        .special (word_special_s)
    );
`else
    assign word_clean_s   = in_data;
    assign word_special_s = 1'b0;
`endif

    // Next-state decode; in_ready_r is already a registered LOAD decode, so accept has no comb path from in_valid to in_ready.
    always_comb begin
        next_state_s = state_r;
        accept_s     = in_valid & in_ready_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = LOAD;
                else       next_state_s = IDLE;
            end
            LOAD: begin
                if (accept_s && (idx_r == LAST_IDX)) next_state_s = FLUSH;
                else                                 next_state_s = LOAD;
            end
            FLUSH:   next_state_s = VALID;
            VALID: begin
                if (layer_ack) next_state_s = IDLE;
                else           next_state_s = VALID;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, index and all outputs; status outputs are registered from the next-state decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= IDLE;
            idx_r           <= FIRST_IDX;
            in_ready_r      <= 1'b0;
            neuron_enable_r <= {NUM_INPUTS{1'b0}};
            neuron_data_r   <= {DATA_WIDTH{1'b0}};
            layer_valid_r   <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            sanitized_r     <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            in_ready_r    <= (next_state_s == LOAD);
            layer_valid_r <= (next_state_s == VALID);
            busy_r        <= (next_state_s != IDLE);
            done_r        <= (state_r == VALID) && (next_state_s == IDLE);

            if (accept_s) begin
                neuron_data_r   <= word_clean_s;
                neuron_enable_r <= ENABLE_LSB << idx_r;
                if (idx_r == LAST_IDX) idx_r <= FIRST_IDX;
                else                   idx_r <= idx_r + IDX_W'(1);
            end else begin
                neuron_enable_r <= {NUM_INPUTS{1'b0}};
                if ((state_r == IDLE) && start) idx_r <= FIRST_IDX;
                else                            idx_r <= idx_r;
            end

            // Sticky until the next honoured start.
            if ((state_r == IDLE) && start)      sanitized_r <= 1'b0;
            else if (accept_s && word_special_s) sanitized_r <= 1'b1;
            else                                 sanitized_r <= sanitized_r;
        end
    end

    assign in_ready      = in_ready_r;
    assign neuron_enable = neuron_enable_r;
    assign neuron_data   = neuron_data_r;
    assign layer_valid   = layer_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign sanitized     = sanitized_r;

endmodule

// File: tb/tb_input_layer_loader.sv
// Directed bench for input_layer_loader: a word-counting reference model plus literal expectations.
module tb_input_layer_loader;

    localparam int N = 4;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          layer_ack = 1'b0;
    logic [31:0]   in_data   = 32'h0;
    logic          in_ready;
    logic [N-1:0]  neuron_enable;
    logic [31:0]   neuron_data;
    logic          layer_valid;
    logic          busy;
    logic          done;
    logic          sanitized;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    input_layer_loader #(.NUM_INPUTS(N), .DATA_WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .neuron_enable (neuron_enable),
        .neuron_data   (neuron_data),
        .layer_valid   (layer_valid),
        .layer_ack     (layer_ack),
        .busy          (busy),
        .done          (done),
        .sanitized     (sanitized)
    );

    // Bench-side neuron bank: plain enabled latches, no reset.
    logic [31:0] neuron [N];
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (neuron_enable[i]) neuron[i] <= neuron_data;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts words into the current vector, then one settle cycle, then holds until ack.
    bit          m_loading  = 1'b0;
    bit          m_settling = 1'b0;
    bit          m_holding  = 1'b0;
    int          m_got      = 0;
    logic [N-1:0] e_enable  = '0;
    logic [31:0] e_data     = 32'h0;
    bit          e_done     = 1'b0;
    bit          e_san      = 1'b0;
    logic [31:0] m_word;
    logic [31:0] m_vec [N];

    always @(posedge clock) begin
        if (reset) begin
            m_loading = 1'b0; m_settling = 1'b0; m_holding = 1'b0;
            m_got = 0; e_enable = '0; e_data = 32'h0; e_done = 1'b0; e_san = 1'b0;
        end else begin
            e_enable = '0;
            e_done   = 1'b0;
            if (m_holding) begin
                if (layer_ack) begin
                    m_holding = 1'b0;
                    e_done    = 1'b1;
                end
            end else if (m_settling) begin
                m_settling = 1'b0;
                m_holding  = 1'b1;
            end else if (m_loading) begin
                if (in_valid) begin
                    m_word = in_data;
`ifdef INPUT_SANITIZE_EN
                    if (m_word[30:23] == 8'hFF) begin
                        m_word = 32'h0;
                        e_san  = 1'b1;
                    end
`endif
                    e_data           = m_word;
                    e_enable[m_got]  = 1'b1;
                    m_vec[m_got]     = m_word;
                    m_got++;
                    if (m_got == N) begin
                        m_loading  = 1'b0;
                        m_settling = 1'b1;
                    end
                end
            end else if (start) begin
                m_loading = 1'b1;
                m_got     = 0;
                e_san     = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    bit          armed     = 1'b0;
    int          done_seen = 0;
    logic [31:0] en_log [$];

    always @(negedge clock) begin
        if (armed) begin
            cmp("in_ready",      32'(in_ready),      32'(m_loading));
            cmp("neuron_enable", 32'(neuron_enable), 32'(e_enable));
            cmp("neuron_data",   neuron_data,        e_data);
            cmp("layer_valid",   32'(layer_valid),   32'(m_holding));
            cmp("busy",          32'(busy),          32'(m_loading | m_settling | m_holding));
            cmp("done",          32'(done),          32'(e_done));
            cmp("sanitized",     32'(sanitized),     32'(e_san));
            if (m_holding && layer_valid) begin
                for (int i = 0; i < N; i++) cmp("neuron_vs_model", neuron[i], m_vec[i]);
            end
            if (neuron_enable != '0) en_log.push_back(32'(neuron_enable));
            if (done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic feed(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
    endtask

    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        en_log.delete();
    endtask

    task automatic wait_lv(input int max_cycles);
        int k = 0;
        while (!layer_valid && k < max_cycles) begin
            tick();
            k++;
        end
        cmp("layer_valid_wait", 32'(layer_valid), 32'd1);
    endtask

    task automatic ack_vector();
        layer_ack = 1'b1;
        tick();
        layer_ack = 1'b0;
        tick();
    endtask

    task automatic check_neurons(input logic [31:0] a, b, c, d);
        cmp("neuron0", neuron[0], a);
        cmp("neuron1", neuron[1], b);
        cmp("neuron2", neuron[2], c);
        cmp("neuron3", neuron[3], d);
    endtask

    task automatic check_onehot_log();
        cmp("enable_count", 32'(en_log.size()), 32'd4);
        for (int k = 0; k < en_log.size() && k < N; k++) begin
            cmp("enable_order", en_log[k], 32'd1 << k);
        end
    endtask

    initial begin
        tick();
        tick();
        armed = 1'b1;
        reset = 1'b0;
        cmp("reset_enable", 32'(neuron_enable), 32'd0);
        cmp("reset_busy",   32'(busy),          32'd0);

        // 1: back-to-back load of 3.0, 1.0, 2.0, 10.0
        begin_load();
        feed(32'h4040_0000); feed(32'h3F80_0000); feed(32'h4000_0000); feed(32'h4120_0000);
        in_valid = 1'b0;
        cmp("lv_one_after_last", 32'(layer_valid), 32'd0);
        tick();
        cmp("lv_two_after_last", 32'(layer_valid), 32'd1);
        check_onehot_log();
        check_neurons(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4120_0000);

        // 2: hold in VALID with in_valid high, then acknowledge
        in_valid  = 1'b1;
        done_seen = 0;
        repeat (10) tick();
        cmp("hold_ready", 32'(in_ready),    32'd0);
        cmp("hold_lv",    32'(layer_valid), 32'd1);
        layer_ack = 1'b1;
        tick();
        layer_ack = 1'b0;
        in_valid  = 1'b0;
        tick();
        tick();
        cmp("done_once", 32'(done_seen), 32'd1);
        cmp("idle_busy", 32'(busy),      32'd0);

        // 3: in_valid toggling every cycle
        begin_load();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 32'h4100_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_lv(5);
        check_onehot_log();
        check_neurons(32'h4100_0000, 32'h4100_0002, 32'h4100_0004, 32'h4100_0006);
        ack_vector();

        // 4: start during LOAD and VALID is ignored; start with ack is dropped
        begin_load();
        feed(32'h3F00_0000); feed(32'hBF00_0000);
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        feed(32'h4080_0000);
        start = 1'b0;
        feed(32'hC080_0000);
        in_valid = 1'b0;
        wait_lv(5);
        start = 1'b1;
        tick();
        tick();
        cmp("start_in_valid", 32'(layer_valid), 32'd1);
        layer_ack = 1'b1;
        tick();
        start     = 1'b0;
        layer_ack = 1'b0;
        tick();
        tick();
        cmp("start_dropped", 32'(busy), 32'd0);
        check_onehot_log();
        check_neurons(32'h3F00_0000, 32'hBF00_0000, 32'h4080_0000, 32'hC080_0000);

        // 5: reset after the second accept, then a clean reload
        begin_load();
        feed(32'h1111_1111); feed(32'h2222_2222);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("rst_ready", 32'(in_ready),      32'd0);
        cmp("rst_busy",  32'(busy),          32'd0);
        cmp("rst_en",    32'(neuron_enable), 32'd0);
        cmp("rst_data",  neuron_data,        32'd0);
        cmp("rst_lv",    32'(layer_valid),   32'd0);
        begin_load();
        feed(32'h4248_0000); feed(32'h42C8_0000); feed(32'hC248_0000); feed(32'h0000_0001);
        in_valid = 1'b0;
        wait_lv(5);
        check_neurons(32'h4248_0000, 32'h42C8_0000, 32'hC248_0000, 32'h0000_0001);
        ack_vector();

        // 6: Inf/NaN words
        begin_load();
        feed(32'h7F80_0000); feed(32'hFFFF_FFFF); feed(32'h8000_0000); feed(32'hBF80_0000);
        in_valid = 1'b0;
        wait_lv(5);
`ifdef INPUT_SANITIZE_EN
        check_neurons(32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'hBF80_0000);
        cmp("sanitized_set", 32'(sanitized), 32'd1);
`else
        check_neurons(32'h7F80_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hBF80_0000);
        cmp("sanitized_off", 32'(sanitized), 32'd0);
`endif
        ack_vector();
        begin_load();
        cmp("sanitized_cleared", 32'(sanitized), 32'd0);
        feed(32'h3F80_0000); feed(32'h4000_0000); feed(32'h4040_0000); feed(32'h4080_0000);
        in_valid = 1'b0;
        wait_lv(5);
        ack_vector();

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
